// File: rtl/bcd_up_counter_2d_pkg.sv
// Shared constants for the BCD counter/display family: seven-segment patterns,
// the BCD limit and the digit-to-segment decoder reused by every display block.
package bcd_up_counter_2d_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Preset values above 9 are pinned to 9 so a digit can never leave BCD range
    function automatic logic [3:0] bcd_clamp(input logic [3:0] value);
        return (value > BCD_MAX) ? BCD_MAX : value;
    endfunction

endpackage

// File: rtl/bcd_up_counter_2d_digit.sv
// One BCD up-counting digit: load beats increment, 9 rolls over to 0 on increment.
module bcd_digit_up
    import bcd_up_counter_2d_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       at_nine
);

    logic [3:0] digit_reg;
    logic [3:0] digit_next;

    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = bcd_clamp(load_val);
        end else if (inc) begin
            // >= rather than == keeps the register in BCD range even after an upset
            digit_next = (digit_reg >= BCD_MAX) ? 4'd0 : digit_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_reg <= 4'd0;
        end else begin
            digit_reg <= digit_next;
        end
    end

    assign digit   = digit_reg;
    assign at_nine = (digit_reg == BCD_MAX);

endmodule

// File: rtl/bcd_up_counter_2d.sv
// Two-digit BCD up counter (00..99) with clock-enable prescaler, preset load,
// wrap or saturate at 99, and direct seven-segment drive for both digits.
module bcd_up_counter_2d
    import bcd_up_counter_2d_pkg::*;
#(
    parameter int DIV_EXP = 22,
    parameter int WRAP    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] load_ones,
    input  logic [3:0] load_tens,
    output logic [3:0] count_ones,
    output logic [3:0] count_tens,
    output logic       carry,
    output logic [6:0] seg7_out,
    output logic [6:0] seg7_tens_out,
    output logic       dpt_out,
    output logic       led_com
);

    localparam logic WRAP_EN = (WRAP != 0);
    localparam int   NUM_DIGITS = 2;

    logic [DIV_EXP-1:0] prescaler_reg;
    logic [DIV_EXP-1:0] prescaler_next;
    logic               tick;
    logic               advance;
    logic               at_max;
    logic               saturated;
    logic               carry_reg;
    logic               carry_next;

    logic [3:0]            load_vals [NUM_DIGITS];
    logic [3:0]            digits    [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] inc_vec;
    logic [NUM_DIGITS-1:0] at_nine_vec;

    // Free-running prescaler; its phase is untouched by load and enable
    assign prescaler_next = prescaler_reg + DIV_EXP'(1);
    assign tick           = &prescaler_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_next;
        end
    end

    assign advance   = tick & enable & ~load;
    assign at_max    = &at_nine_vec;
    assign saturated = ~WRAP_EN & at_max;

    // Digit i advances when every lower digit sits at nine
    assign inc_vec[0] = advance & ~saturated;
    assign inc_vec[1] = advance & ~saturated & at_nine_vec[0];

    assign load_vals[0] = load_ones;
    assign load_vals[1] = load_tens;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_up u_digit (
                .clk      (clk),
                .reset    (reset),
                .inc      (inc_vec[gi]),
                .load     (load),
                .load_val (load_vals[gi]),
                .digit    (digits[gi]),
                .at_nine  (at_nine_vec[gi])
            );
        end
    endgenerate

    // Carry fires only on the 99 -> 00 wrap; the count is 00 afterwards so it cannot repeat
    assign carry_next = advance & at_max & WRAP_EN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_reg <= 1'b0;
        end else begin
            carry_reg <= carry_next;
        end
    end

    assign count_ones    = digits[0];
    assign count_tens    = digits[1];
    assign carry         = carry_reg;
    assign seg7_out      = bcd_to_seg7(digits[0]);
    assign seg7_tens_out = bcd_to_seg7(digits[1]);
    assign dpt_out       = 1'b0;
    assign led_com       = 1'b0;

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// Randomised and directed bench for bcd_up_counter_2d: a wrapping and a saturating
// instance share stimulus and are compared every cycle against an integer model.
module tb_bcd_up_counter_2d;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_ones = 4'd0;
    logic [3:0] load_tens = 4'd0;

    logic [3:0] ones_w, tens_w, ones_s, tens_s;
    logic       carry_w, carry_s, dpt_w, dpt_s, com_w, com_s;
    logic [6:0] seg_w, segt_w, seg_s, segt_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    int m_val [2];
    int m_carry [2];
    int m_pre;

    logic [6:0] seg_tab [10];

    always #5 clk = ~clk;

    bcd_up_counter_2d #(.DIV_EXP(2), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_ones(load_ones), .load_tens(load_tens),
        .count_ones(ones_w), .count_tens(tens_w), .carry(carry_w),
        .seg7_out(seg_w), .seg7_tens_out(segt_w), .dpt_out(dpt_w), .led_com(com_w)
    );

    bcd_up_counter_2d #(.DIV_EXP(2), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_ones(load_ones), .load_tens(load_tens),
        .count_ones(ones_s), .count_tens(tens_s), .carry(carry_s),
        .seg7_out(seg_s), .seg7_tens_out(segt_s), .dpt_out(dpt_s), .led_com(com_s)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic int min9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    task automatic model_reset();
        m_pre = 0;
        for (int w = 0; w < 2; w++) begin
            m_val[w] = 0;
            m_carry[w] = 0;
        end
    endtask

    // Model index 0 wraps, index 1 saturates
    task automatic model_edge();
        bit tick;
        tick = (m_pre == DIV - 1);
        m_pre = (m_pre + 1) % DIV;
        for (int w = 0; w < 2; w++) begin
            m_carry[w] = 0;
            if (load) begin
                m_val[w] = min9(int'(load_tens)) * 10 + min9(int'(load_ones));
            end else if (tick && enable) begin
                if (m_val[w] < 99) begin
                    m_val[w] = m_val[w] + 1;
                end else if (w == 0) begin
                    m_val[w] = 0;
                    m_carry[w] = 1;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, " w.val"},   int'(tens_w) * 10 + int'(ones_w), m_val[0]);
        check({tag, " w.carry"}, int'(carry_w), m_carry[0]);
        check({tag, " w.seg"},   int'(seg_w),  int'(seg_tab[m_val[0] % 10]));
        check({tag, " w.segt"},  int'(segt_w), int'(seg_tab[m_val[0] / 10]));
        check({tag, " s.val"},   int'(tens_s) * 10 + int'(ones_s), m_val[1]);
        check({tag, " s.carry"}, int'(carry_s), m_carry[1]);
        check({tag, " s.seg"},   int'(seg_s),  int'(seg_tab[m_val[1] % 10]));
        check({tag, " s.segt"},  int'(segt_s), int'(seg_tab[m_val[1] / 10]));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
        $display("%s: load=%0d en=%0d -> wrap=%0d%0d c=%0d sat=%0d%0d c=%0d",
                 tag, load, enable, tens_w, ones_w, carry_w, tens_s, ones_s, carry_s);
    endtask

    task automatic do_load(input int tens, input int ones);
        load = 1'b1;
        load_tens = 4'(tens);
        load_ones = 4'(ones);
        cycle("load");
        load = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    // Advance until the next edge samples a tick
    task automatic align_to_tick();
        int guard = 0;
        while (m_pre != DIV - 1 && guard < DIV) begin
            cycle("align");
            guard++;
        end
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset seg7_out raw", int'(seg_w), 'b1000000);
        check("dpt_out", int'(dpt_w | dpt_s), 0);
        check("led_com", int'(com_w | com_s), 0);
        reset = 1'b0;
        enable = 1'b1;

        // First change lands on the 4th edge after release
        run("first", 3);
        check("no change before tick", int'(ones_w), 0);
        cycle("first tick");
        check("first tick ones", int'(ones_w), 1);
        check("seg for 1", int'(seg_w), 'b1111001);
        run("count", 40);

        // Wrap vs saturate at 99
        do_load(9, 9);
        align_to_tick();
        cycle("at99 tick");
        check("wrap carry pulse", int'(carry_w), 1);
        cycle("after wrap");
        check("carry one clk", int'(carry_w), 0);
        run("post99", 6);

        // Clamp of out-of-range presets
        do_load(12, 15);
        check("clamp wrap", int'(tens_w) * 10 + int'(ones_w), 99);

        // Load colliding with an enabled tick
        align_to_tick();
        do_load(3, 4);
        check("load beats tick", int'(tens_w) * 10 + int'(ones_w), 34);
        check("load carry 0", int'(carry_w), 0);

        // Frozen across three ticks, then exactly one increment
        enable = 1'b0;
        run("frozen", 12);
        check("frozen value", int'(tens_w) * 10 + int'(ones_w), 34);
        enable = 1'b1;
        align_to_tick();
        cycle("reenable");
        check("reenable +1", int'(tens_w) * 10 + int'(ones_w), 35);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 24) == 0);
            load_tens = 4'($urandom_range(0, 15));
            load_ones = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) begin
                load = 1'b1;
                load_tens = 4'd9;
                load_ones = 4'($urandom_range(7, 9));
            end
            cycle("rand");
        end
        load = 1'b0;
        enable = 1'b1;

        // Asynchronous reset between edges at 47
        do_load(4, 7);
        run("pre-reset", 2);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async reset");
        check("async seg", int'(seg_w), 'b1000000);
        @(posedge clk);
        #2;
        reset = 1'b0;
        run("resume", 3);
        check("resume hold", int'(ones_w), 0);
        cycle("resume tick");
        check("resume first", int'(ones_w), 1);
        run("resume run", 8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_up_counter_2d.md
# bcd_up_counter_2d

Two-digit BCD up counter (00→99) with built-in tick prescaler, synchronous preset load and wrap/saturate modes. It drives the two DE10-Lite seven-segment digits directly, complementing the existing 99→00 down counter. The block is fully synchronous in one clock domain: the prescaler produces a clock-enable tick, and no divided clock or ripple borrow/carry clocks are used. It sits at top level between the board switches/keys and the HEX displays.

## Interface
Parameters:
- DIV_EXP, 22: prescaler width; one count tick every 2^DIV_EXP clk cycles (legal range 1..26).
- WRAP, 1: 1 = wrap 99→00; 0 = saturate at 99.

Ports:
- clk  input  1  board clock (50 MHz); all logic on its rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- enable  input  1  level count enable, sampled on tick cycles.
- load  input  1  synchronous preset strobe.
- load_ones  input  4  BCD ones preset.
- load_tens  input  4  BCD tens preset.
- count_ones  output  4  registered ones digit.
- count_tens  output  4  registered tens digit.
- carry  output  1  registered one-clk pulse on 99→00 wrap.
- seg7_out  output  7  ones digit, active-low, bit0=a … bit6=g.
- seg7_tens_out  output  7  tens digit, same encoding.
- dpt_out  output  1  tied 0.
- led_com  output  1  tied 0.

## Operation
- Prescaler: DIV_EXP-bit free-running counter. tick = 1 for the single cycle in which the prescaler is all-ones. It runs regardless of enable and load.
- Priority at each clk edge: load > (tick & enable) > hold.
- Load: count ← {load_tens, load_ones}. Any preset digit >9 is clamped to 9. carry = 0 that cycle.
- Advance (tick & enable):
  - ones <9: ones+1.
  - ones = 9, tens <9: ones←0, tens+1.
  - 99 with WRAP=1: count←00, carry←1.
  - 99 with WRAP=0: hold 99, carry←0.
- carry is 0 in every cycle not described above. It is never high on two consecutive cycles.
- Display: seg outputs are combinational decode of the registered digits. Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other value (unreachable) = 1111111.
- Count registers never hold a non-BCD value.

## Timing
- Reset values:
  - count_ones = count_tens = 0.
  - carry = 0.
  - prescaler = 0.
  - seg7_out = seg7_tens_out = 1000000.
- First tick is in cycle 2^DIV_EXP − 1 after reset release. Ticks then occur every 2^DIV_EXP cycles.
- Count and carry update at the edge that samples tick & enable (registered, 1-edge latency). Segments follow in the same cycle (0 extra latency).
- Load takes effect at the next edge, 1-cycle latency, and does not reset the prescaler phase.
- If enable drops on a tick cycle, that tick is lost; it is not deferred.
- Reset asserted mid-operation clears all state immediately (asynchronous). The prescaler restarts from 0 on release.

## Structure
- Shared include (constants): the ten seven-segment patterns and the blank pattern, plus the BCD_MAX = 4'd9 constant. These are reused by the down counter and future display blocks.
- Sub-module bcd_digit_up (one digit):
  - inputs: clk, reset, inc, load, load_val.
  - outputs: digit, at_nine.
- The top instantiates two bcd_digit_up digits. The tens inc = tick & enable & ones at_nine, qualified by the WRAP/saturate logic.
- Decoding reuses the existing bcd_to_seg7.

## Test plan
Run with DIV_EXP = 2, so a tick occurs every 4 clks.
- Reset then enable = 1 → counts advance 00,01,…,09,10 on successive ticks. First change at the 4th clk edge after release. seg7_out for 1 = 1111001.
- Load 9,9 with WRAP=1, then tick → count = 00 and carry high for exactly 1 clk. With WRAP=0 → stays 99 and carry stays 0.
- Load tens = 12, ones = 15 → count = 99 (clamped). Load asserted on a tick cycle with enable = 1 → load value wins and carry = 0.
- enable = 0 across 3 ticks → count frozen. Re-enable → next tick increments by exactly 1.
- Assert reset mid-count (e.g. at 47) between clk edges → outputs immediately show 00 and segments 1000000. Count resumes 4 clks after release.
